mpu_i2c_responder: RTL and testbench

- Synthesizable I2C target that emulates the MPU-6050 register interface at the far end of the flight controller's I2C master.
- Used in simulation and FPGA hardware-in-loop so the attitude/PID path can run against scripted sensor data without a physical IMU.
- Covers 7-bit address match, register-pointer write, data write, and auto-increment burst read with a coherent sensor snapshot.
- Sits on the scl/sda bus as an open-drain device; a test-side port loads the 14 sensor bytes.

---
 rtl/mpu_i2c_responder.sv | 237 +++++++++++++++++++++++
 tb/tb_mpu_i2c_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_i2c_responder.sv
// MPU-6050 register-interface emulator on an open-drain I2C bus.
// Sensor bytes come in through a side port and are frozen into a snapshot at each read-address ACK.
module mpu_i2c_responder #(
   parameter logic [6:0] DEV_ADDR     = 7'h68,
   parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
   parameter logic [7:0] PWR_RST_VAL  = 8'h40
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   input  logic       sens_wr,
   input  logic [3:0] sens_idx,
   input  logic [7:0] sens_data,
   output logic [7:0] pwr_mgmt,
   output logic       addr_hit,
   output logic       bus_busy
);

   typedef enum logic [3:0] {
      StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
      StWdata, StWdataAck, StRdata, StRdAckChk, StIgnore
   } state_e;

   localparam logic [7:0] RegSensLo = 8'h3B;
   localparam logic [7:0] RegSensHi = 8'h48;
   localparam logic [7:0] RegPwr    = 8'h6B;
   localparam logic [7:0] RegWho    = 8'h75;

   // [0],[1] synchronize; [2] is the previous synchronized value for edge detection
   logic [2:0] scl_sync_q, sda_sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sync_q <= 3'b111;
         sda_sync_q <= 3'b111;
      end else begin
         scl_sync_q <= {scl_sync_q[1:0], scl};
         sda_sync_q <= {sda_sync_q[1:0], sda_in};
      end
   end

   logic scl_rise, scl_fall, start_cond, stop_cond, sda_bit;

   assign sda_bit    = sda_sync_q[1];
   assign scl_rise   = scl_sync_q[1] & ~scl_sync_q[2];
   assign scl_fall   = ~scl_sync_q[1] & scl_sync_q[2];
   assign start_cond = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[1] & sda_sync_q[2];
   assign stop_cond  = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[1] & ~sda_sync_q[2];

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] ptr_q, ptr_d;
   logic [7:0] pwr_q, pwr_d;
   logic       oe_q, oe_d;
   logic       busy_q, busy_d;
   logic       hit_q, hit_d;
   logic       rw_q, rw_d;
   logic       snap_load;

   logic [7:0] shadow_q [14];
   logic [7:0] snap_q   [14];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 14; i++) begin
            shadow_q[i] <= 8'h00;
            snap_q[i]   <= 8'h00;
         end
      end else begin
         if (sens_wr && (sens_idx < 4'd14)) begin
            shadow_q[sens_idx] <= sens_data;
         end
         if (snap_load) begin
            for (int i = 0; i < 14; i++) begin
               snap_q[i] <= shadow_q[i];
            end
         end
      end
   end

   logic [7:0] sens_off;
   logic [7:0] rd_byte;

   always_comb begin
      sens_off = ptr_q - RegSensLo;
      rd_byte  = 8'h00;
      if ((ptr_q >= RegSensLo) && (ptr_q <= RegSensHi)) begin
         rd_byte = snap_q[sens_off[3:0]];
      end else if (ptr_q == RegPwr) begin
         rd_byte = pwr_q;
      end else if (ptr_q == RegWho) begin
         rd_byte = WHO_AM_I_VAL;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         shift_q <= 8'h00;
         tx_q    <= 8'h00;
         ptr_q   <= 8'h00;
         pwr_q   <= PWR_RST_VAL;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         hit_q   <= 1'b0;
         rw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         ptr_q   <= ptr_d;
         pwr_q   <= pwr_d;
         oe_q    <= oe_d;
         busy_q  <= busy_d;
         hit_q   <= hit_d;
         rw_q    <= rw_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      ptr_d     = ptr_q;
      pwr_d     = pwr_q;
      oe_d      = oe_q;
      busy_d    = busy_q;
      hit_d     = 1'b0;
      rw_d      = rw_q;
      snap_load = 1'b0;
      if (start_cond) begin
         state_d = StAddr;
         cnt_d   = 4'd0;
         oe_d    = 1'b0;
         busy_d  = 1'b1;
      end else if (stop_cond) begin
         state_d = StIdle;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else if (scl_rise) begin
         case (state_q)
            StAddr, StPtr, StWdata: begin
               shift_d = {shift_q[6:0], sda_bit};
               cnt_d   = cnt_q + 4'd1;
            end
            StRdata: cnt_d = cnt_q + 4'd1;
            StRdAckChk: begin
               if (sda_bit) begin
                  state_d = StIgnore;
               end
            end
            default: ;
         endcase
      end else if (scl_fall) begin
         case (state_q)
            StAddr: begin
               if (cnt_q == 4'd8) begin
                  cnt_d = 4'd0;
                  if (shift_q[7:1] == DEV_ADDR) begin
                     state_d   = StAddrAck;
                     oe_d      = 1'b1;
                     hit_d     = 1'b1;
                     rw_d      = shift_q[0];
                     snap_load = shift_q[0];
                  end else begin
                     state_d = StIgnore;
                  end
               end
            end
            StAddrAck: begin
               if (rw_q) begin
                  state_d = StRdata;
                  oe_d    = ~rd_byte[7];
                  tx_d    = {rd_byte[6:0], 1'b0};
               end else begin
                  state_d = StPtr;
                  oe_d    = 1'b0;
               end
            end
            StPtr: begin
               if (cnt_q == 4'd8) begin
                  ptr_d   = shift_q;
                  cnt_d   = 4'd0;
                  oe_d    = 1'b1;
                  state_d = StPtrAck;
               end
            end
            StPtrAck, StWdataAck: begin
               oe_d    = 1'b0;
               state_d = StWdata;
            end
            StWdata: begin
               if (cnt_q == 4'd8) begin
                  if (ptr_q == RegPwr) begin
                     pwr_d = shift_q;
                  end
                  ptr_d   = ptr_q + 8'd1;
                  cnt_d   = 4'd0;
                  oe_d    = 1'b1;
                  state_d = StWdataAck;
               end
            end
            StRdata: begin
               if (cnt_q == 4'd8) begin
                  oe_d    = 1'b0;
                  ptr_d   = ptr_q + 8'd1;
                  cnt_d   = 4'd0;
                  state_d = StRdAckChk;
               end else begin
                  oe_d = ~tx_q[7];
                  tx_d = {tx_q[6:0], 1'b0};
               end
            end
            // Reaching this fall means the master ACKed; NACK already left at the rise
            StRdAckChk: begin
               state_d = StRdata;
               oe_d    = ~rd_byte[7];
               tx_d    = {rd_byte[6:0], 1'b0};
            end
            default: ;
         endcase
      end
   end

   assign sda_oe   = oe_q;
   assign pwr_mgmt = pwr_q;
   assign addr_hit = hit_q;
   assign bus_busy = busy_q;

endmodule

// File: tb/tb_mpu_i2c_responder.sv
// Directed bench for mpu_i2c_responder: bit-banged I2C master, register-read table, corner sequences.
module tb_mpu_i2c_responder;

   localparam int Q = 6;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_bus;
   logic       sda_oe;
   logic       sens_wr = 1'b0;
   logic [3:0] sens_idx = 4'd0;
   logic [7:0] sens_data = 8'h00;
   logic [7:0] pwr_mgmt;
   logic       addr_hit;
   logic       bus_busy;

   int n_checks = 0;
   int n_errors = 0;
   int hit_cnt = 0;
   int oe_cnt = 0;

   assign sda_bus = sda_m & ~sda_oe;

   mpu_i2c_responder dut (
      .clk      (clk),
      .reset    (reset),
      .scl      (scl),
      .sda_in   (sda_bus),
      .sda_oe   (sda_oe),
      .sens_wr  (sens_wr),
      .sens_idx (sens_idx),
      .sens_data(sens_data),
      .pwr_mgmt (pwr_mgmt),
      .addr_hit (addr_hit),
      .bus_busy (bus_busy)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (addr_hit) hit_cnt++;
      if (sda_oe) oe_cnt++;
   end

   initial begin
      #1800000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [7:0] ra;
      logic [7:0] exp;
   } rd_vec_t;

   rd_vec_t vecs [9];

   task automatic wq(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wq(Q);
      scl = 1'b1;   wq(Q);
      sda_m = 1'b0; wq(Q);
      scl = 1'b0;   wq(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wq(Q);
      scl = 1'b1;   wq(Q);
      sda_m = 1'b1; wq(Q);
   endtask

   // ack = sampled SDA during the ninth clock (0 means the target ACKed)
   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i]; wq(Q);
         scl = 1'b1;   wq(2 * Q);
         scl = 1'b0;   wq(Q);
      end
      sda_m = 1'b1; wq(Q);
      scl = 1'b1;   wq(Q);
      ack = sda_bus; wq(Q);
      scl = 1'b0;   wq(Q);
   endtask

   task automatic read_byte(input logic master_ack, output logic [7:0] b);
      sda_m = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         wq(Q);
         scl = 1'b1; wq(Q);
         b[i] = sda_bus; wq(Q);
         scl = 1'b0; wq(Q);
      end
      sda_m = ~master_ack; wq(Q);
      scl = 1'b1;   wq(2 * Q);
      scl = 1'b0;   wq(Q);
      sda_m = 1'b1;
   endtask

   task automatic read_reg(input logic [7:0] ra, output logic [7:0] d, output logic [2:0] acks);
      logic a;
      i2c_start();
      write_byte(8'hD0, a); acks[2] = a;
      write_byte(ra, a);    acks[1] = a;
      i2c_start();
      write_byte(8'hD1, a); acks[0] = a;
      read_byte(1'b0, d);
      i2c_stop();
   endtask

   task automatic sens_load(input logic [3:0] idx, input logic [7:0] val);
      sens_idx = idx; sens_data = val; sens_wr = 1'b1;
      wq(1);
      sens_wr = 1'b0;
      wq(1);
   endtask

   initial begin
      logic       a;
      logic [7:0] d;
      logic [2:0] acks;
      int         h0;
      int         o0;

      vecs[0] = '{8'h3B, 8'h10};
      vecs[1] = '{8'h40, 8'h15};
      vecs[2] = '{8'h48, 8'h1D};
      vecs[3] = '{8'h75, 8'h68};
      vecs[4] = '{8'h6B, 8'h40};
      vecs[5] = '{8'h00, 8'h00};
      vecs[6] = '{8'h49, 8'h00};
      vecs[7] = '{8'h3A, 8'h00};
      vecs[8] = '{8'hFF, 8'h00};

      wq(3);
      reset = 1'b0;
      wq(2);
      check1("reset sda_oe", sda_oe, 1'b0);
      check1("reset bus_busy", bus_busy, 1'b0);
      check1("reset addr_hit", addr_hit, 1'b0);
      check8("reset pwr_mgmt", pwr_mgmt, 8'h40);

      // WHO_AM_I with repeated START
      h0 = hit_cnt;
      i2c_start();
      check1("busy after start", bus_busy, 1'b1);
      write_byte(8'hD0, a); check1("who ack addr_w", a, 1'b0);
      write_byte(8'h75, a); check1("who ack ptr", a, 1'b0);
      i2c_start();
      write_byte(8'hD1, a); check1("who ack addr_r", a, 1'b0);
      read_byte(1'b0, d);   check8("who_am_i data", d, 8'h68);
      i2c_stop();
      check1("who sda_oe after stop", sda_oe, 1'b0);
      check1("who busy after stop", bus_busy, 1'b0);
      check_int("who addr_hit pulses", hit_cnt - h0, 2);

      for (int i = 0; i < 14; i++) sens_load(4'(i), 8'h10 + 8'(i));
      sens_load(4'd14, 8'hEE);
      sens_load(4'd15, 8'hEE);

      for (int i = 0; i < 9; i++) begin
         read_reg(vecs[i].ra, d, acks);
         check8($sformatf("table acks reg 0x%02h", vecs[i].ra), {5'b0, acks}, 8'h00);
         check8($sformatf("table data reg 0x%02h", vecs[i].ra), d, vecs[i].exp);
      end

      // 14-byte burst, then pointer must sit at 0x49
      i2c_start();
      write_byte(8'hD0, a); write_byte(8'h3B, a);
      i2c_start();
      write_byte(8'hD1, a); check1("burst ack addr_r", a, 1'b0);
      for (int i = 0; i < 14; i++) begin
         read_byte(i < 13, d);
         check8($sformatf("burst byte %0d", i), d, 8'h10 + 8'(i));
      end
      i2c_stop();
      i2c_start();
      write_byte(8'hD1, a);
      read_byte(1'b0, d);
      i2c_stop();
      check8("burst ptr end 0x49", d, 8'h00);

      // Snapshot coherence: shadow write mid-burst must not leak into this burst
      i2c_start();
      write_byte(8'hD0, a); write_byte(8'h3B, a);
      i2c_start();
      write_byte(8'hD1, a);
      for (int i = 0; i < 6; i++) begin
         read_byte(i < 5, d);
         check8($sformatf("coherent byte %0d", i), d, 8'h10 + 8'(i));
         if (i == 1) sens_load(4'd5, 8'hFF);
      end
      i2c_stop();
      read_reg(8'h40, d, acks);
      check8("snapshot refresh 0x40", d, 8'hFF);

      // Register writes
      i2c_start();
      write_byte(8'hD0, a); check1("wr ack addr", a, 1'b0);
      write_byte(8'h6B, a); check1("wr ack ptr", a, 1'b0);
      write_byte(8'h00, a); check1("wr ack data", a, 1'b0);
      i2c_stop();
      check8("pwr_mgmt after write", pwr_mgmt, 8'h00);
      read_reg(8'h6B, d, acks);
      check8("read back 0x6B", d, 8'h00);
      i2c_start();
      write_byte(8'hD0, a); write_byte(8'h6A, a);
      write_byte(8'h77, a); write_byte(8'h5A, a); write_byte(8'h33, a);
      check1("wr burst last ack", a, 1'b0);
      i2c_stop();
      check8("pwr_mgmt after auto-inc write", pwr_mgmt, 8'h5A);

      // Address miss must leave bus and pointer alone
      i2c_start();
      write_byte(8'hD0, a); write_byte(8'h6B, a);
      i2c_stop();
      h0 = hit_cnt;
      o0 = oe_cnt;
      i2c_start();
      write_byte(8'hA0, a); check1("miss addr nack", a, 1'b1);
      write_byte(8'h75, a); check1("miss ptr nack", a, 1'b1);
      i2c_stop();
      check_int("miss sda_oe cycles", oe_cnt - o0, 0);
      check_int("miss addr_hit pulses", hit_cnt - h0, 0);
      i2c_start();
      write_byte(8'hD1, a);
      read_byte(1'b0, d);
      i2c_stop();
      check8("miss ptr unchanged", d, 8'h5A);

      // Reset while the target is pulling SDA low in a read
      i2c_start();
      write_byte(8'hD0, a); write_byte(8'h6B, a);
      i2c_start();
      write_byte(8'hD1, a);
      check1("midread sda_oe driving", sda_oe, 1'b1);
      reset = 1'b1;
      wq(1);
      reset = 1'b0;
      check1("midread reset sda_oe", sda_oe, 1'b0);
      check8("midread reset pwr_mgmt", pwr_mgmt, 8'h40);
      check1("midread reset busy", bus_busy, 1'b0);
      i2c_stop();
      i2c_start();
      write_byte(8'hD1, a); check1("post-reset ack", a, 1'b0);
      read_byte(1'b0, d);
      i2c_stop();
      check8("post-reset reg 0x00", d, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
